// File: rtl/imem_loader_pkg.sv
// Shared definitions for the imem writer (loader) and the imem reader.
// The byte-lane mapping is big-endian: lane 0 is the first byte of a word.
package imem_loader_pkg;

    localparam int IMEM_ADDR_W      = 10;
    localparam int IMEM_DEPTH_WORDS = 1024;
    localparam int IMEM_CNT_W       = 16;

    // Lane 0 occupies [31:24], lane 3 occupies [7:0].
    localparam int         LANE0_LSB = 24;
    localparam logic [1:0] LANE_LAST = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_t;

    // Least-significant bit of a byte lane inside a 32-bit word.
    function automatic logic [4:0] lane_lsb(input logic [1:0] lane);
        return 5'(LANE0_LSB) - {lane, 3'b000};
    endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// Four-lane big-endian byte packer. Bytes fill lanes 0..3 in order;
// lanes not yet written stay zero, so a flushed partial word is zero-padded.
module imem_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        resetB,
    input  logic        clear,
    input  logic        load,
    input  logic        last,
    input  logic [7:0]  byte_in,
    output logic [1:0]  byte_idx,
    output logic [31:0] word_next,
    output logic        word_full,
    output logic        flush
);

    logic [31:0] pack;

    // Word as it will look once the incoming byte is placed in its lane.
    always_comb begin
        word_next = pack;
        word_next[lane_lsb(byte_idx) +: 8] = byte_in;
    end

    assign word_full = load && (byte_idx == LANE_LAST);
    assign flush     = load && last;

    // Lane register and lane pointer; clear wins over a concurrent load.
    always_ff @(posedge clk or negedge resetB) begin
        if (!resetB) begin
            pack     <= '0;
            byte_idx <= '0;
        end else if (clear) begin
            pack     <= '0;
            byte_idx <= '0;
        end else if (load) begin
            pack     <= word_next;
            byte_idx <= byte_idx + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Writer side of the instruction memory: packs a host byte stream into
// big-endian 32-bit words and writes them to imem from word address 0.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for load_start, host_byte_ready low
// ST_ACCUM | accepting host bytes into the packer
// ST_WRITE | single cycle with ceb/web low, word captured on next edge
// ST_DONE  | load finished, expected_bytes/load_done published
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W      = IMEM_ADDR_W,
    parameter int DEPTH_WORDS = IMEM_DEPTH_WORDS,
    parameter int CNT_W       = IMEM_CNT_W
) (
    input  logic              clk,
    input  logic              resetB,
    input  logic              load_start,
    input  logic              host_byte_valid,
    input  logic [7:0]        host_byte,
    input  logic              host_last,
    output logic              host_byte_ready,
    output logic              imem_ceb,
    output logic              imem_web,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [CNT_W-1:0]  expected_bytes,
    output logic              load_done,
    output logic              load_overflow
);

    localparam logic [CNT_W-1:0]  FULL_BYTES = CNT_W'(DEPTH_WORDS * 4);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH_WORDS - 1);

    loader_state_t    state;
    logic [CNT_W-1:0] byte_count;
    logic             last_seen;

    logic        xfer;
    logic        pack_clear;
    logic [1:0]  byte_idx;
    logic [31:0] word_next;
    logic        word_full;
    logic        flush;

    // A restart always beats a transfer in the same cycle.
    assign xfer       = host_byte_valid && host_byte_ready
                        && (state == ST_ACCUM) && !load_start;
    assign pack_clear = load_start || (state == ST_WRITE);

    imem_byte_packer u_packer (
        .clk       (clk),
        .resetB    (resetB),
        .clear     (pack_clear),
        .load      (xfer),
        .last      (host_last),
        .byte_in   (host_byte),
        .byte_idx  (byte_idx),
        .word_next (word_next),
        .word_full (word_full),
        .flush     (flush)
    );

    // Load sequencing FSM with registered imem, handshake and status outputs.
    always_ff @(posedge clk or negedge resetB) begin
        if (!resetB) begin
            state           <= ST_IDLE;
            byte_count      <= '0;
            last_seen       <= 1'b0;
            host_byte_ready <= 1'b0;
            imem_ceb        <= 1'b1;
            imem_web        <= 1'b1;
            imem_addr       <= '0;
            imem_wdata      <= '0;
            expected_bytes  <= '0;
            load_done       <= 1'b0;
            load_overflow   <= 1'b0;
        end else if (load_start) begin
            // Restart from any state; a pending partial word is dropped.
            state           <= ST_ACCUM;
            byte_count      <= '0;
            last_seen       <= 1'b0;
            host_byte_ready <= 1'b1;
            imem_ceb        <= 1'b1;
            imem_web        <= 1'b1;
            imem_addr       <= '0;
            expected_bytes  <= '0;
            load_done       <= 1'b0;
            load_overflow   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    host_byte_ready <= 1'b0;
                end

                ST_ACCUM: begin
                    if (xfer) begin
                        byte_count <= byte_count + CNT_W'(1);
                        if (host_last) begin
                            last_seen <= 1'b1;
                        end
                        if (word_full || flush) begin
                            imem_wdata      <= word_next;
                            imem_ceb        <= 1'b0;
                            imem_web        <= 1'b0;
                            host_byte_ready <= 1'b0;
                            state           <= ST_WRITE;
                        end
                    end
                end

                ST_WRITE: begin
                    imem_ceb <= 1'b1;
                    imem_web <= 1'b1;
                    // The final word of a full image sits at LAST_ADDR; hold
                    // there rather than wrap back to 0.
                    if (imem_addr != LAST_ADDR) begin
                        imem_addr <= imem_addr + ADDR_W'(1);
                    end
                    if (last_seen || (byte_count == FULL_BYTES)) begin
                        state          <= ST_DONE;
                        expected_bytes <= byte_count;
                        load_done      <= 1'b1;
                        // Only reachable without last_seen when imem is full.
                        load_overflow  <= !last_seen;
                    end else begin
                        state           <= ST_ACCUM;
                        host_byte_ready <= 1'b1;
                    end
                end

                ST_DONE: begin
                    host_byte_ready <= 1'b0;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
